// File: rtl/seg_scan_scheduler.sv
// Multiplexed 7-segment scan scheduler: time-slices up to eight digits with
// inter-digit blanking and a fixed-length slot whose lit fraction follows brightness.
module seg_scan_scheduler #(
    parameter int SLICE_CLKS = 6250,
    parameter int BLANK_CLKS = 64
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Wr_En,
    input  logic [2:0] i_Wr_Addr,
    input  logic [6:0] i_Wr_Data,
    input  logic [7:0] i_Digit_Mask,
    input  logic [3:0] i_Brightness,
    output logic [6:0] o_Segment_Display,
    output logic [7:0] o_Segment_En,
    output logic       o_Frame_Done
);

    localparam int SLOT_CLKS = BLANK_CLKS + 16 * SLICE_CLKS;
    localparam int CW        = $clog2(SLOT_CLKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_OFF   = 2'd3
    } state_t;

    state_t          state_r;
    logic [2:0]      cur_r;
    logic [CW-1:0]   cnt_r;
    logic [3:0]      bl_r;
    logic [6:0]      pat_r;
    logic [6:0]      buf_r [0:7];

    logic            blank_last_s;
    logic            on_last_s;
    logic            off_last_s;
    logic            slot_end_s;
    logic [2:0]      next_s;
    logic [2:0]      lowest_s;
    logic [6:0]      latch_pat_s;

    // Next set mask bit strictly above cur, wrapping; cur itself only if it is the sole set bit.
    function automatic logic [2:0] next_digit(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] idx;
        logic [2:0] res;
        res = cur;
        for (int k = 8; k >= 1; k--) begin
            idx = cur + 3'(k);
            if (mask[idx]) begin
                res = idx;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] lowest_digit(input logic [7:0] mask);
        logic [2:0] res;
        res = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (mask[k]) begin
                res = 3'(k);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Phase-end detection and next-digit selection.
    always_comb begin
        blank_last_s = (cnt_r == CW'(BLANK_CLKS - 1));
        on_last_s    = (cnt_r == CW'(SLICE_CLKS * (int'(bl_r) + 1) - 1));
        off_last_s   = (cnt_r == CW'(SLICE_CLKS * (15 - int'(bl_r)) - 1));
        slot_end_s   = ((state_r == ST_ON) && on_last_s && (bl_r == 4'd15)) ||
                       ((state_r == ST_OFF) && off_last_s);
        next_s       = next_digit(i_Digit_Mask, cur_r);
        lowest_s     = lowest_digit(i_Digit_Mask);
    end

    // Write-first view of the current digit's buffer entry for the latch on the last BLANK cycle.
    always_comb begin
        if (i_Wr_En && (i_Wr_Addr == cur_r)) begin
            latch_pat_s = i_Wr_Data;
        end else begin
            latch_pat_s = buf_r[cur_r];
        end
    end

    // Digit buffer storage.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= 7'h7F;
            end
        end else if (i_Wr_En) begin
            buf_r[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // Scan FSM with registered display outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r           <= ST_IDLE;
            cur_r             <= 3'd0;
            cnt_r             <= '0;
            bl_r              <= 4'd0;
            pat_r             <= 7'h7F;
            o_Segment_En      <= 8'hFF;
            o_Segment_Display <= 7'h7F;
            o_Frame_Done      <= 1'b0;
        end else begin
            o_Frame_Done <= 1'b0;
            if (slot_end_s) begin
                // Slot boundary: mask is sampled only here so the running slot is never resized.
                cnt_r             <= '0;
                o_Segment_En      <= 8'hFF;
                o_Segment_Display <= 7'h7F;
                if (i_Digit_Mask == 8'h00) begin
                    state_r <= ST_IDLE;
                end else begin
                    state_r      <= ST_BLANK;
                    cur_r        <= next_s;
                    o_Frame_Done <= (next_s <= cur_r);
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        o_Segment_En      <= 8'hFF;
                        o_Segment_Display <= 7'h7F;
                        cnt_r             <= '0;
                        if (i_Digit_Mask != 8'h00) begin
                            state_r <= ST_BLANK;
                            cur_r   <= lowest_s;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_BLANK: begin
                        if (blank_last_s) begin
                            state_r           <= ST_ON;
                            cnt_r             <= '0;
                            bl_r              <= i_Brightness;
                            pat_r             <= latch_pat_s;
                            o_Segment_En      <= ~(8'b1 << cur_r);
                            o_Segment_Display <= latch_pat_s;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_ON: begin
                        if (on_last_s) begin
                            state_r           <= ST_OFF;
                            cnt_r             <= '0;
                            o_Segment_En      <= 8'hFF;
                            o_Segment_Display <= 7'h7F;
                        end else begin
                            cnt_r             <= cnt_r + CW'(1);
                            o_Segment_Display <= pat_r;
                        end
                    end
                    ST_OFF: begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                    default: begin
                        state_r           <= ST_IDLE;
                        cnt_r             <= '0;
                        o_Segment_En      <= 8'hFF;
                        o_Segment_Display <= 7'h7F;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Randomized and directed bench for seg_scan_scheduler against a slot-offset reference model.
module tb_seg_scan_scheduler;

    localparam int SLICE = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = BLANK + 16 * SLICE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [6:0] wr_data = 7'd0;
    logic [7:0] mask = 8'h00;
    logic [3:0] bri = 4'd0;
    logic [6:0] seg;
    logic [7:0] en;
    logic       fd;

    int checks = 0;
    int errors = 0;

    // Model: whether a scan is running, which digit, and the cycle offset within the slot.
    bit         m_active;
    int         m_digit;
    int         m_t;
    int         m_b;
    logic [6:0] m_pat;
    logic       m_fd;
    logic [6:0] m_buf [8];

    seg_scan_scheduler #(.SLICE_CLKS(SLICE), .BLANK_CLKS(BLANK)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr),
        .i_Wr_Data(wr_data), .i_Digit_Mask(mask), .i_Brightness(bri),
        .o_Segment_Display(seg), .o_Segment_En(en), .o_Frame_Done(fd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_digit  = 0;
        m_t      = 0;
        m_b      = 0;
        m_pat    = 7'h7F;
        m_fd     = 1'b0;
        for (int i = 0; i < 8; i++) m_buf[i] = 7'h7F;
    endtask

    function automatic int next_set(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++) begin
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        end
        return cur;
    endfunction

    task automatic model_edge();
        int nd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_fd = 1'b0;
        if (!m_active) begin
            if (mask != 8'h00) begin
                m_active = 1'b1;
                m_digit  = next_set(mask, 7);
                m_t      = 0;
            end
        end else begin
            if (m_t == BLANK - 1) begin
                m_b   = int'(bri);
                m_pat = (wr_en && int'(wr_addr) == m_digit) ? wr_data : m_buf[m_digit];
            end
            if (m_t == SLOT - 1) begin
                m_t = 0;
                if (mask == 8'h00) begin
                    m_active = 1'b0;
                end else begin
                    nd      = next_set(mask, m_digit);
                    m_fd    = (nd <= m_digit);
                    m_digit = nd;
                end
            end else begin
                m_t++;
            end
        end
        if (wr_en) m_buf[wr_addr] = wr_data;
    endtask

    function automatic logic lit();
        return m_active && (m_t >= BLANK) && (m_t < BLANK + SLICE * (m_b + 1));
    endfunction

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic step();
        logic [7:0] e_en;
        logic [6:0] e_seg;
        @(posedge clk);
        model_edge();
        #1;
        e_en  = lit() ? ~(8'b1 << m_digit) : 8'hFF;
        e_seg = lit() ? m_pat : 7'h7F;
        check("en", 32'(en), 32'(e_en));
        check("seg", 32'(seg), 32'(e_seg));
        check("frame_done", 32'(fd), 32'(m_fd));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        mask  = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [6:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        int on_cnt;
        model_reset();

        // Reset state
        do_reset();
        check("rst_en", 32'(en), 32'h0FF);
        check("rst_seg", 32'(seg), 32'h07F);
        check("rst_fd", 32'(fd), 32'h0);

        // Two digits at full brightness
        wr(3'd0, 7'h40);
        wr(3'd1, 7'h79);
        mask = 8'h03;
        bri  = 4'd15;
        for (int k = 1; k <= 140; k++) begin
            step();
            if (k == 2)   check("s1_blank", 32'(en), 32'h0FF);
            if (k == 3)   check("s1_on0_en", 32'(en), 32'h0FE);
            if (k == 3)   check("s1_on0_seg", 32'(seg), 32'h040);
            if (k == 66)  check("s1_on0_last", 32'(en), 32'h0FE);
            if (k == 67)  check("s1_blank1", 32'(en), 32'h0FF);
            if (k == 67)  check("s1_no_fd", 32'(fd), 32'h0);
            if (k == 69)  check("s1_on1_en", 32'(en), 32'h0FD);
            if (k == 69)  check("s1_on1_seg", 32'(seg), 32'h079);
            if (k == 133) check("s1_fd", 32'(fd), 32'h1);
        end

        // Single digit at minimum brightness
        do_reset();
        mask   = 8'h01;
        bri    = 4'd0;
        fd_cnt = 0;
        on_cnt = 0;
        for (int k = 1; k <= 132; k++) begin
            step();
            if (en == 8'hFE) on_cnt++;
            if (fd) fd_cnt++;
            if (k == 6) check("s2_on_last", 32'(en), 32'h0FE);
            if (k == 7) check("s2_off", 32'(en), 32'h0FF);
        end
        check("s2_on_cycles", 32'(on_cnt), 32'd8);
        check("s2_fd_count", 32'(fd_cnt), 32'd1);

        // Sparse mask order 0,4,7,0
        do_reset();
        mask   = 8'h91;
        bri    = 4'd15;
        fd_cnt = 0;
        for (int k = 1; k <= 264; k++) begin
            step();
            if (fd) fd_cnt++;
            if (k == 3)   check("s3_d0", 32'(en), 32'h0FE);
            if (k == 69)  check("s3_d4", 32'(en), 32'h0EF);
            if (k == 135) check("s3_d7", 32'(en), 32'h07F);
            if (k == 199) check("s3_fd", 32'(fd), 32'h1);
            if (k == 201) check("s3_d0b", 32'(en), 32'h0FE);
        end
        check("s3_fd_count", 32'(fd_cnt), 32'd1);

        // Write to the lit digit takes effect next slot
        do_reset();
        wr(3'd0, 7'h33);
        mask = 8'h01;
        bri  = 4'd7;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (k == 12) check("s4_old", 32'(seg), 32'h033);
            if (k == 69) check("s4_new", 32'(seg), 32'h012);
            if (k == 10) begin
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = 7'h12;
            end else begin
                wr_en = 1'b0;
            end
        end

        // Mask cleared mid-slot, then restored to digit 2
        do_reset();
        mask   = 8'h03;
        bri    = 4'd15;
        fd_cnt = 0;
        for (int k = 1; k <= 90; k++) begin
            step();
            if (fd) fd_cnt++;
            if (k == 66) check("s5_slot_done", 32'(en), 32'h0FE);
            if (k == 67) check("s5_idle", 32'(en), 32'h0FF);
            if (k == 78) check("s5_idle2", 32'(en), 32'h0FF);
            if (k == 82) check("s5_d2", 32'(en), 32'h0FB);
            if (k == 20) mask = 8'h00;
            if (k == 79) mask = 8'h04;
        end
        check("s5_fd_count", 32'(fd_cnt), 32'd0);

        // Asynchronous reset during ON
        do_reset();
        wr(3'd0, 7'h55);
        mask = 8'h01;
        bri  = 4'd15;
        for (int k = 1; k <= 10; k++) step();
        check("s6_on", 32'(en), 32'h0FE);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_en", 32'(en), 32'h0FF);
        check("s6_async_seg", 32'(seg), 32'h07F);
        mask = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        mask  = 8'h01;
        for (int k = 1; k <= 3; k++) step();
        check("s6_buf_cleared", 32'(seg), 32'h07F);
        check("s6_resume_en", 32'(en), 32'h0FE);

        // Randomized traffic against the model
        do_reset();
        mask = 8'h5A;
        for (int k = 0; k < 3000; k++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 99) == 0) begin
                mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 49) == 0) bri = 4'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 SHALL have parameter SLICE_CLKS, default 6250, giving clocks per brightness sixteenth of a digit slot.
REQ-002 SHALL have parameter BLANK_CLKS, default 64, giving the inter-digit blanking clocks (anti-ghosting), minimum 1.
REQ-003 SHALL have port i_Clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_Wr_En  in  1  digit-buffer write strobe, one write per cycle.
REQ-006 SHALL have port i_Wr_Addr  in  3  digit index 0..7 to write.
REQ-007 SHALL have port i_Wr_Data  in  7  active-low segment pattern, stored unmodified.
REQ-008 SHALL have port i_Digit_Mask  in  8  bit n=1 includes digit n in the scan.
REQ-009 SHALL have port i_Brightness  in  4  on-time code B; on-time is (B+1) sixteenths of the lit portion.
REQ-010 SHALL have port o_Segment_Display  out  7  active-low segments of the lit digit.
REQ-011 SHALL have port o_Segment_En  out  8  active-low digit enables; at most one bit 0 at any time.
REQ-012 SHALL have port o_Frame_Done  out  1  one-cycle pulse at the end of each complete scan.

Function
REQ-013 SHALL hold an 8x7 digit buffer; a write with i_Wr_En=1 updates entry i_Wr_Addr at the clock edge.
REQ-014 SHALL implement states IDLE, BLANK, ON, OFF; every output SHALL be registered.
REQ-015 IDLE: o_Segment_En=8'hFF, o_Segment_Display=7'h7F; on the first cycle with i_Digit_Mask!=0, go to BLANK with the current digit set to the lowest set mask bit.
REQ-016 BLANK: enables 8'hFF, segments 7'h7F for exactly BLANK_CLKS cycles; on the last cycle, latch i_Brightness as Bl and the current digit's buffer entry, then go to ON.
REQ-017 ON: enable bit of the current digit =0, segments = latched pattern, for exactly SLICE_CLKS*(Bl+1) cycles; then go to OFF, or end the slot if Bl=15.
REQ-018 OFF: enables 8'hFF, segments 7'h7F for exactly SLICE_CLKS*(15-Bl) cycles; then end the slot.
REQ-019 The slot length SHALL be exactly BLANK_CLKS+16*SLICE_CLKS cycles, independent of B.
REQ-020 At slot end, SHALL sample i_Digit_Mask and select the next set bit above the current digit, wrapping 7->0 (the current digit itself is chosen only if it is the sole set bit), then enter BLANK. If the mask is 0, SHALL enter IDLE.
REQ-021 o_Frame_Done SHALL pulse high for one cycle, coincident with the first BLANK cycle, whenever the next-digit selection wraps (the next index is less than or equal to the current index). It SHALL NOT pulse on entry from IDLE.
REQ-022 A write to the digit currently in ON or OFF SHALL NOT alter the displayed pattern until that digit's next slot. A write during BLANK on the last BLANK cycle SHALL be latched (write-first).
REQ-023 Mask or brightness changes mid-slot SHALL NOT shorten or extend the slot in progress.
REQ-024 Counters SHALL be sized for SLICE_CLKS*16+BLANK_CLKS without overflow.

Reset
REQ-025 While i_Rst_n=0, SHALL force: state IDLE, current digit 0, counters 0, all buffer entries 7'h7F, o_Segment_En=8'hFF, o_Segment_Display=7'h7F, o_Frame_Done=0.
REQ-026 Reset asserted mid-slot SHALL blank the outputs immediately (asynchronously). After release, operation SHALL resume per REQ-015.

Verification (SLICE_CLKS=4, BLANK_CLKS=2, slot=66 clocks)
REQ-027 Reset, write digit0=7'h40 and digit1=7'h79, mask=8'h03, B=15: the bench SHALL see 2 blank cycles, then 64 cycles of En=8'hFE/Seg=7'h40, then 2 blank cycles, then 64 cycles of En=8'hFD/Seg=7'h79, and Frame_Done on the first cycle of the second digit-0 slot.
REQ-028 Mask=8'h01, B=0: the bench SHALL see per 66-cycle slot 2 blank, 4 on (En=8'hFE), 60 off, with Frame_Done once per slot.
REQ-029 Mask=8'h91: the digit order SHALL be 0,4,7,0 and Frame_Done SHALL occur only on the 7->0 transition.
REQ-030 Write digit0=7'h12 during digit0's ON phase: the bench SHALL see the old pattern until the slot ends and 7'h12 in the next digit-0 slot.
REQ-031 Set mask to 0 mid-slot: the slot SHALL complete, then IDLE with En=8'hFF; restoring mask=8'h04 SHALL restart at digit 2 with no Frame_Done.
REQ-032 Assert i_Rst_n=0 during ON: En=8'hFF and Seg=7'h7F SHALL appear the same cycle without a clock edge, and the buffer SHALL read 7'h7F afterward.
